instr_fetch_reg: RTL and testbench
==================================

INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 SHALL have parameter RESET_INSTR, default 32'h00000000: instruction register value after reset (NOP).
REQ-002 SHALL have ports, in order:
  clk  input  1  single clock; all state updates on posedge
  reset  input  1  synchronous, active-high
  fetch_req  input  1  controller request to fetch the instruction at pc
  pc  input  32  fetch byte address, sampled when fetch_req is accepted
  mem_address  output  32  bus address (registered)
  mem_read  output  1  bus read strobe (registered)
  mem_waitrequest  input  1  bus stall; read completes in a cycle where mem_read=1 and mem_waitrequest=0
  mem_readdata  input  32  bus read data, valid on the completion cycle
  busy  output  1  high while in READ
  instr_valid  output  1  instr holds a completed fetch
  fetch_err  output  1  last accepted request had pc[1:0]!=0
  instr  output  32  instruction register
  opcode  output  6  instr[31:26]
  rs  output  5  instr[25:21]
  rt  output  5  instr[20:16]
  rd  output  5  instr[15:11]
  shamt  output  5  instr[10:6]
  funct  output  6  instr[5:0]
  immdt_16  output  16  instr[15:0]; feeds the immediate extender
  target_26  output  26  instr[25:0]
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.

Function
REQ-004 FSM SHALL have two states: IDLE, READ; busy=1 exactly in READ.
REQ-005 IDLE, fetch_req=1, pc[1:0]==0: SHALL latch mem_address<=pc, mem_read<=1, instr_valid<=0, fetch_err<=0, go READ.
REQ-006 IDLE, fetch_req=1, pc[1:0]!=0: SHALL issue no bus read, set fetch_err<=1, instr_valid<=0, leave instr unchanged, stay IDLE.
REQ-007 READ: mem_address and mem_read SHALL stay constant while mem_waitrequest=1, for any number of cycles.
REQ-008 READ, mem_waitrequest=0: SHALL load instr<=mem_readdata (per REQ-016), instr_valid<=1, mem_read<=0, go IDLE.
REQ-009 fetch_req SHALL be ignored while in READ; no queuing.
REQ-010 Latency: fetch_req accepted at edge N -> mem_read=1 during cycle N..N+1; zero wait states -> instr_valid=1 after edge N+1; each wait cycle adds one.
REQ-011 instr, instr_valid, fetch_err SHALL hold until the next accepted fetch_req or reset.
REQ-012 Field outputs SHALL be pure combinational slices of instr; no extra latency.
REQ-013 Back-to-back: fetch_req held high SHALL start the next fetch on the first IDLE cycle after completion, giving one IDLE cycle with instr_valid=1 between reads.

Reset
REQ-014 reset SHALL take priority over all other inputs, including mid-READ; on reset: state IDLE, mem_read=0, mem_address=0, instr=RESET_INSTR, instr_valid=0, fetch_err=0.
REQ-015 A bus transfer in progress at reset SHALL be abandoned; its data SHALL not be loaded.

Configuration
REQ-016 Macro FETCH_BYTESWAP_EN: defined -> instr loaded as {readdata[7:0],readdata[15:8],readdata[23:16],readdata[31:24]} (little-endian bus); undefined -> instr loaded as mem_readdata unchanged.

Verification
REQ-017 Reset then idle: instr=32'h00000000, instr_valid=0, mem_read=0, fetch_err=0.
REQ-018 fetch_req, pc=32'hBFC00000, zero wait, readdata=32'h2408FFFF (macro off) -> mem_address=32'hBFC00000 one cycle, then opcode=6'h09, rs=0, rt=8, immdt_16=16'hFFFF, instr_valid=1.
REQ-019 Same read with mem_waitrequest=1 for 3 cycles -> mem_read/mem_address stable 4 cycles, busy=1 throughout, instr_valid=1 one cycle after release.
REQ-020 fetch_req, pc=32'h00000006 -> mem_read stays 0, fetch_err=1, instr unchanged; next aligned fetch clears fetch_err.
REQ-021 reset asserted in 2nd wait cycle -> next cycle mem_read=0, instr=RESET_INSTR, instr_valid=0; late readdata ignored.
REQ-022 FETCH_BYTESWAP_EN defined, readdata=32'hFFFF0824 -> instr=32'h2408FFFF.

Source files
------------

// File: rtl/instr_fetch_reg.sv
// Instruction fetch register: issues one bus read per accepted fetch request,
// holds the fetched word and decodes its fields. Optional macro: FETCH_BYTESWAP_EN.
module instr_fetch_reg #(
    parameter logic [31:0] RESET_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        busy,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immdt_16,
    output logic [25:0] target_26
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t state;

    // Little-endian buses deliver the first instruction byte in the low lane.
    function automatic logic [31:0] load_word(input logic [31:0] d);
`ifdef FETCH_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_address <= 32'h00000000;
            mem_read    <= 1'b0;
            instr       <= RESET_INSTR;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        instr_valid <= 1'b0;
                        if (pc[1:0] == 2'b00) begin
                            mem_address <= pc;
                            mem_read    <= 1'b1;
                            fetch_err   <= 1'b0;
                            state       <= READ;
                        end else begin
                            // Misaligned: report and stay put, no bus traffic.
                            fetch_err   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    // Address and strobe simply hold while the bus stalls.
                    if (!mem_waitrequest) begin
                        instr       <= load_word(mem_readdata);
                        instr_valid <= 1'b1;
                        mem_read    <= 1'b0;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = (state == READ);

    assign opcode    = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign shamt     = instr[10:6];
    assign funct     = instr[5:0];
    assign immdt_16  = instr[15:0];
    assign target_26 = instr[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Self-checking bench for instr_fetch_reg: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_instr_fetch_reg;

    localparam logic [31:0] RESET_INSTR = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] pc;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        busy;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] immdt_16;
    logic [25:0] target_26;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one outstanding transaction and the last fetch result.
    bit          m_pending;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_err;

    instr_fetch_reg #(.RESET_INSTR(RESET_INSTR)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc(pc),
        .mem_address(mem_address), .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .busy(busy), .instr_valid(instr_valid), .fetch_err(fetch_err),
        .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .immdt_16(immdt_16), .target_26(target_26)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] bus_to_instr(input logic [31:0] d);
        logic [31:0] r = d;
`ifdef FETCH_BYTESWAP_EN
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            r = r | (((d >> (8 * i)) & 32'hFF) << (8 * (3 - i)));
`endif
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_step();
        if (reset) begin
            m_pending = 1'b0;
            m_addr    = 32'h0;
            m_instr   = RESET_INSTR;
            m_valid   = 1'b0;
            m_err     = 1'b0;
        end else if (m_pending) begin
            if (!mem_waitrequest) begin
                m_instr   = bus_to_instr(mem_readdata);
                m_valid   = 1'b1;
                m_pending = 1'b0;
            end
        end else if (fetch_req) begin
            m_valid = 1'b0;
            if (pc % 4 == 0) begin
                m_addr    = pc;
                m_pending = 1'b1;
                m_err     = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("mem_read", 32'(mem_read), 32'(m_pending));
        check("busy", 32'(busy), 32'(m_pending));
        if (m_pending) check("mem_address", mem_address, m_addr);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("fetch_err", 32'(fetch_err), 32'(m_err));
        check("instr", instr, m_instr);
        check("opcode", 32'(opcode), m_instr / 32'h0400_0000);
        check("rs", 32'(rs), (m_instr / 32'h0020_0000) % 32);
        check("rt", 32'(rt), (m_instr / 32'h0001_0000) % 32);
        check("rd", 32'(rd), (m_instr / 32'h0000_0800) % 32);
        check("shamt", 32'(shamt), (m_instr / 32'h40) % 32);
        check("funct", 32'(funct), m_instr % 64);
        check("immdt_16", 32'(immdt_16), m_instr % 32'h1_0000);
        check("target_26", 32'(target_26), m_instr % 32'h0400_0000);
    endtask

    // Inputs are driven after the falling edge; outputs are checked there too.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic drive(input bit r, input bit f, input logic [31:0] a,
                         input bit w, input logic [31:0] d);
        reset = r; fetch_req = f; pc = a; mem_waitrequest = w; mem_readdata = d;
    endtask

    logic [31:0] word_2408;

    initial begin
`ifdef FETCH_BYTESWAP_EN
        word_2408 = 32'hFFFF0824;
`else
        word_2408 = 32'h2408FFFF;
`endif
        drive(1, 0, 32'h0, 0, 32'h0);
        cycle();
        cycle();

        // Reset then idle.
        drive(0, 0, 32'h0, 0, 32'h0);
        cycle();
        check("rst_instr", instr, 32'h00000000);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_read", 32'(mem_read), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);
        check("rst_addr", mem_address, 32'h0);

        // Zero-wait fetch from the boot vector.
        drive(0, 1, 32'hBFC00000, 0, word_2408);
        cycle();
        check("z_read", 32'(mem_read), 32'h1);
        check("z_addr", mem_address, 32'hBFC00000);
        drive(0, 0, 32'h0, 0, word_2408);
        cycle();
        check("z_instr", instr, 32'h2408FFFF);
        check("z_opcode", 32'(opcode), 32'h09);
        check("z_rs", 32'(rs), 32'h0);
        check("z_rt", 32'(rt), 32'h8);
        check("z_imm", 32'(immdt_16), 32'hFFFF);
        check("z_valid", 32'(instr_valid), 32'h1);
        check("z_read_done", 32'(mem_read), 32'h0);

        // Same read with three wait states; a request during READ is ignored.
        drive(0, 1, 32'hBFC00000, 1, 32'h0);
        cycle();
        drive(0, 1, 32'h00000040, 1, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("w_read", 32'(mem_read), 32'h1);
            check("w_addr", mem_address, 32'hBFC00000);
            check("w_busy", 32'(busy), 32'h1);
            check("w_valid", 32'(instr_valid), 32'h0);
        end
        drive(0, 0, 32'h0, 0, word_2408);
        cycle();
        check("w_done_valid", 32'(instr_valid), 32'h1);
        check("w_done_instr", instr, 32'h2408FFFF);

        // Misaligned request, then an aligned one clears the error.
        drive(0, 1, 32'h00000006, 0, 32'h0);
        cycle();
        check("m_read", 32'(mem_read), 32'h0);
        check("m_err", 32'(fetch_err), 32'h1);
        check("m_instr", instr, 32'h2408FFFF);
        drive(0, 1, 32'h00000100, 0, 32'h12345678);
        cycle();
        check("m_clear_err", 32'(fetch_err), 32'h0);
        check("m_clear_read", 32'(mem_read), 32'h1);

        // Request held high: completion, one idle cycle with valid, next read.
        drive(0, 1, 32'h00000104, 0, 32'h12345678);
        cycle();
        check("b2b_valid", 32'(instr_valid), 32'h1);
        check("b2b_idle", 32'(busy), 32'h0);
        cycle();
        check("b2b_next_read", 32'(mem_read), 32'h1);
        check("b2b_next_addr", mem_address, 32'h00000104);
        drive(0, 0, 32'h0, 0, 32'hCAFEF00D);
        cycle();

        // Reset during the second wait cycle abandons the transfer.
        drive(0, 1, 32'h00000200, 1, 32'h0);
        cycle();
        drive(0, 0, 32'h0, 1, 32'h0);
        cycle();
        drive(1, 0, 32'h0, 1, 32'h0);
        cycle();
        check("r_read", 32'(mem_read), 32'h0);
        check("r_instr", instr, RESET_INSTR);
        check("r_valid", 32'(instr_valid), 32'h0);
        drive(0, 0, 32'h0, 0, 32'hA5A5A5A5);
        cycle();
        check("r_late_instr", instr, RESET_INSTR);
        check("r_late_valid", 32'(instr_valid), 32'h0);

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = $urandom & 32'hFFFF_FFF0;
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            else a = a | 32'(4 * $urandom_range(0, 3));
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, a,
                  $urandom_range(0, 9) < 4, $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
